gray_box_overlay: RTL

Parametrised pixel-stream processor for the camera-to-display path. It converts incoming RGB to colour, grayscale or binary-threshold output and overlays a rectangular marker at a programmable X/Y position, such as a pupil-tracker result. It sits between the raw-to-RGB stage and the display/SDRAM writer. It has a fixed-latency pipeline and tear-free position updates latched at frame start.

---
 rtl/gray_box_pkg.sv | 19 +
 rtl/gray_box_overlay_rgb2gray.sv | 60 ++++++
 rtl/gray_box_overlay.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/gray_box_pkg.sv
// Shared definitions for the gray/threshold pixel path with box overlay.
// Holds the output mode encodings and the luma coefficients.
// Pure definitions: no latency and no flow control.
package gray_box_pkg;

  typedef enum logic [1:0] {
    MODE_COLOR    = 2'd0,
    MODE_GRAY     = 2'd1,
    MODE_THRESH   = 2'd2,
    MODE_GRAY_ALT = 2'd3
  } mode_e;

  // BT.601-style luma weights scaled by 256.
  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

endpackage

// File: rtl/gray_box_overlay_rgb2gray.sv
// Pipelined luma (77R+150G+29B)>>8 with a threshold compare against a carried threshold.
// Latency 2 cycles: products registered, then sum/shift/compare registered.
// No backpressure: advances every cycle.
module rgb2gray
  import gray_box_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] red_i,
  input  logic [DW-1:0] grn_i,
  input  logic [DW-1:0] blu_i,
  input  logic [DW-1:0] thresh_i,
  output logic [DW-1:0] gray_o,
  output logic          ge_o
);

  localparam int PW = DW + 8;

  logic [PW-1:0] pr_d, pr_q, pg_d, pg_q, pb_d, pb_q;
  logic [DW-1:0] thr_d, thr_q;
  logic [DW-1:0] gray_d, gray_q;
  logic          ge_d, ge_q;
  logic [PW-1:0] sum;

  // Stage 1 products; stage 2 sum, shift and threshold compare.
  always_comb begin
    pr_d   = PW'(LUMA_R) * PW'(red_i);
    pg_d   = PW'(LUMA_G) * PW'(grn_i);
    pb_d   = PW'(LUMA_B) * PW'(blu_i);
    thr_d  = thresh_i;
    sum    = pr_q + pg_q + pb_q;
    gray_d = DW'(sum >> LUMA_SHIFT);
    ge_d   = (gray_d >= thr_q);
  end

  // Pipeline registers for both luma stages.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      thr_q  <= '0;
      gray_q <= '0;
      ge_q   <= 1'b0;
    end else begin
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      thr_q  <= thr_d;
      gray_q <= gray_d;
      ge_q   <= ge_d;
    end
  end

  assign gray_o = gray_q;
  assign ge_o   = ge_q;

endmodule

// File: rtl/gray_box_overlay.sv
// Colour/gray/threshold pixel stream with a rectangular marker overlay; BOX_BORDER_EN makes the marker hollow.
// Latency 3 cycles fixed; oDVAL is iDVAL delayed by 3.
// No backpressure: pipeline advances every cycle; marker position changes latch at frame start.
module gray_box_overlay
  import gray_box_pkg::*;
#(
  parameter int DW        = 10,
  parameter int CW        = 13,
  parameter int BOX_W     = 40,
  parameter int BOX_H     = 40,
  parameter int BORDER    = 2,
  parameter int BOX_COLOR = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [CW-1:0] iH_Cont,
  input  logic [CW-1:0] iV_Cont,
  input  logic [CW-1:0] iPosX,
  input  logic [CW-1:0] iPosY,
  input  logic          iPosLoad,
  input  logic [1:0]    iMode,
  input  logic [DW-1:0] iThresh,
  output logic          oDVAL,
  output logic [DW-1:0] oDATA_R,
  output logic [DW-1:0] oDATA_G,
  output logic [DW-1:0] oDATA_B,
  output logic          oInBox
);

  localparam logic [DW-1:0] BOX_VAL = DW'(BOX_COLOR);
  localparam logic [CW:0]   BW      = (CW+1)'(BOX_W);
  localparam logic [CW:0]   BH      = (CW+1)'(BOX_H);

  // Position registers: pending holds the latest load until the next frame start.
  logic [CW-1:0] act_x_d, act_x_q, act_y_d, act_y_q;
  logic [CW-1:0] pend_x_d, pend_x_q, pend_y_d, pend_y_q;
  logic          pend_vld_d, pend_vld_q;
  logic          frame_start;

  // Box compare, done in one bit wider than the counters so the far edge clips.
  logic [CW:0] h_ext, v_ext, x_lo, x_hi, y_lo, y_hi;
  logic        in_rect, box_hit;

  // Pipeline state.
  logic          s1_vld_d, s1_vld_q, s1_box_d, s1_box_q;
  logic [DW-1:0] s1_r_d, s1_r_q, s1_g_d, s1_g_q, s1_b_d, s1_b_q;
  mode_e         s1_mode_d, s1_mode_q;
  logic          s2_vld_d, s2_vld_q, s2_box_d, s2_box_q;
  logic [DW-1:0] s2_r_d, s2_r_q, s2_g_d, s2_g_q, s2_b_d, s2_b_q;
  mode_e         s2_mode_d, s2_mode_q;
  logic          o_vld_d, o_vld_q, o_box_d, o_box_q;
  logic [DW-1:0] o_r_d, o_r_q, o_g_d, o_g_q, o_b_d, o_b_q;
  logic [DW-1:0] gray;
  logic          gray_ge;

  // Tear-free position update: swap in pending (or a same-cycle load) only at frame start.
  always_comb begin
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_vld_d  = pend_vld_q;
    frame_start = iDVAL && (iH_Cont == '0) && (iV_Cont == '0);
    if (frame_start) begin
      pend_vld_d = 1'b0;
      if (iPosLoad) begin
        act_x_d = iPosX;
        act_y_d = iPosY;
      end else if (pend_vld_q) begin
        act_x_d = pend_x_q;
        act_y_d = pend_y_q;
      end
    end else if (iPosLoad) begin
      pend_x_d   = iPosX;
      pend_y_d   = iPosY;
      pend_vld_d = 1'b1;
    end
  end

  // Marker membership uses the position taking effect this cycle, so the frame-start pixel sees it.
  always_comb begin
    h_ext   = {1'b0, iH_Cont};
    v_ext   = {1'b0, iV_Cont};
    x_lo    = {1'b0, act_x_d};
    y_lo    = {1'b0, act_y_d};
    x_hi    = x_lo + BW;
    y_hi    = y_lo + BH;
    in_rect = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
`ifdef BOX_BORDER_EN
    box_hit = in_rect &&
              ((h_ext < x_lo + (CW+1)'(BORDER)) || (h_ext >= x_hi - (CW+1)'(BORDER)) ||
               (v_ext < y_lo + (CW+1)'(BORDER)) || (v_ext >= y_hi - (CW+1)'(BORDER)));
`else
    box_hit = in_rect;
`endif
  end

  rgb2gray #(.DW(DW)) u_rgb2gray (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .red_i    (iRed),
    .grn_i    (iGreen),
    .blu_i    (iBlue),
    .thresh_i (iThresh),
    .gray_o   (gray),
    .ge_o     (gray_ge)
  );

  // Delay line alongside the luma pipe, then the mode/marker output mux.
  always_comb begin
    s1_vld_d  = iDVAL;
    s1_box_d  = box_hit;
    s1_r_d    = iRed;
    s1_g_d    = iGreen;
    s1_b_d    = iBlue;
    s1_mode_d = mode_e'(iMode);
    s2_vld_d  = s1_vld_q;
    s2_box_d  = s1_box_q;
    s2_r_d    = s1_r_q;
    s2_g_d    = s1_g_q;
    s2_b_d    = s1_b_q;
    s2_mode_d = s1_mode_q;
    o_vld_d   = s2_vld_q;
    o_box_d   = s2_box_q;
    o_r_d     = gray;
    o_g_d     = gray;
    o_b_d     = gray;
    if (s2_box_q) begin
      o_r_d = BOX_VAL;
      o_g_d = BOX_VAL;
      o_b_d = BOX_VAL;
    end else if (s2_mode_q == MODE_COLOR) begin
      o_r_d = s2_r_q;
      o_g_d = s2_g_q;
      o_b_d = s2_b_q;
    end else if (s2_mode_q == MODE_THRESH) begin
      o_r_d = {DW{gray_ge}};
      o_g_d = {DW{gray_ge}};
      o_b_d = {DW{gray_ge}};
    end
  end

  // All state registers; reset flushes the pipe and clears both position sets.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      act_x_q    <= '0;
      act_y_q    <= '0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_vld_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_box_q   <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_COLOR;
      s2_vld_q   <= 1'b0;
      s2_box_q   <= 1'b0;
      s2_r_q     <= '0;
      s2_g_q     <= '0;
      s2_b_q     <= '0;
      s2_mode_q  <= MODE_COLOR;
      o_vld_q    <= 1'b0;
      o_box_q    <= 1'b0;
      o_r_q      <= '0;
      o_g_q      <= '0;
      o_b_q      <= '0;
    end else begin
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_vld_q <= pend_vld_d;
      s1_vld_q   <= s1_vld_d;
      s1_box_q   <= s1_box_d;
      s1_r_q     <= s1_r_d;
      s1_g_q     <= s1_g_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_vld_q   <= s2_vld_d;
      s2_box_q   <= s2_box_d;
      s2_r_q     <= s2_r_d;
      s2_g_q     <= s2_g_d;
      s2_b_q     <= s2_b_d;
      s2_mode_q  <= s2_mode_d;
      o_vld_q    <= o_vld_d;
      o_box_q    <= o_box_d;
      o_r_q      <= o_r_d;
      o_g_q      <= o_g_d;
      o_b_q      <= o_b_d;
    end
  end

  assign oDVAL   = o_vld_q;
  assign oInBox  = o_box_q;
  assign oDATA_R = o_r_q;
  assign oDATA_G = o_g_q;
  assign oDATA_B = o_b_q;

endmodule
